// File: rtl/freq_meter_mc_pkg.sv
// Shared types for the multi-channel reciprocal frequency / duty meter.
package freq_meter_pkg;

  // Widest counter any instance may use; results are carried at this width
  // between the channel holding register and the output register.
  localparam int RES_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_MEAS  = 3'd2,
    ST_CLOSE = 3'd3,
    ST_DONE  = 3'd4
  } ch_state_e;

  typedef enum logic {
    MODE_FREQ = 1'b0,
    MODE_DUTY = 1'b1
  } meas_mode_e;

  typedef struct packed {
    logic                 ovf;
    logic [RES_CNT_W-1:0] ref_cnt;
    logic [RES_CNT_W-1:0] val_cnt;
  } res_t;

endpackage

// File: rtl/freq_meter_mc_ch.sv
// One measurement channel: synchroniser, rise detect, window FSM, counters
// and a single-entry holding register with a pending flag.
//
// state  | meaning
// IDLE   | channel off; waits for run & enable
// ARM    | waiting for the rise that opens a window (that edge is not counted)
// MEAS   | gate timer running; ref / value counters running
// CLOSE  | gate expired; counters still run until the closing rise (counted)
// DONE   | one cycle; result goes to the holding register or is dropped
module freq_meter_ch
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             i_sig,
  input  logic             i_run,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_gate_time,
  input  logic             i_take,
  output logic             o_pend,
  output res_t             o_res,
  output logic             o_lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sig_d;
  logic                   w_sig;
  logic                   w_rise;
  logic                   w_val_inc;

  ch_state_e              r_state;
  meas_mode_e             r_mode;
  logic [CNT_W-1:0]       r_gate_time;
  logic [CNT_W-1:0]       r_gate_cnt;
  logic [CNT_W-1:0]       r_ref_cnt;
  logic [CNT_W-1:0]       r_val_cnt;
  logic                   r_ovf;
  res_t                   r_hold;
  logic                   r_pend;
  logic                   r_lost;

  // Bring the asynchronous pin into clk_i and keep one delayed copy for edge detect
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync  <= '0;
      r_sig_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_sig_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sig     = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_sig & ~r_sig_d;
  // FREQ counts rising edges, DUTY counts reference cycles with the signal high
  assign w_val_inc = (r_mode == MODE_FREQ) ? w_rise : w_sig;

  // Window FSM, counters and holding register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_FREQ;
      r_gate_time <= '0;
      r_gate_cnt  <= '0;
      r_ref_cnt   <= '0;
      r_val_cnt   <= '0;
      r_ovf       <= 1'b0;
      r_hold      <= '0;
      r_pend      <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      if (i_take) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_run && i_en) begin
            r_state     <= ST_ARM;
            r_mode      <= meas_mode_e'(i_mode);
            r_gate_time <= i_gate_time;
          end
        end

        ST_ARM: begin
          if (!i_en) begin
            r_state <= ST_IDLE;
          end else if (w_rise) begin
            // Configuration is taken at the opening edge so it applies to the whole window
            r_state     <= ST_MEAS;
            r_mode      <= meas_mode_e'(i_mode);
            r_gate_time <= i_gate_time;
            r_gate_cnt  <= '0;
            r_ref_cnt   <= '0;
            r_val_cnt   <= '0;
            r_ovf       <= 1'b0;
          end
        end

        ST_MEAS, ST_CLOSE: begin
          if (!i_en) begin
            r_state <= ST_IDLE;
          end else if (r_ref_cnt == CNT_MAX) begin
            // Reference counter full: the signal has stalled, close without an edge
            r_ovf   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
            if (w_val_inc) begin
              if (r_val_cnt == CNT_MAX) begin
                r_ovf <= 1'b1;
              end else begin
                r_val_cnt <= r_val_cnt + 1'b1;
              end
            end
            if (r_state == ST_MEAS) begin
              if (r_gate_cnt != CNT_MAX) begin
                r_gate_cnt <= r_gate_cnt + 1'b1;
              end
              if (r_gate_cnt == r_gate_time) begin
                r_state <= ST_CLOSE;
              end
            end else if (w_rise) begin
              r_state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (r_pend) begin
            r_lost <= 1'b1;
          end else begin
            r_hold.ovf     <= r_ovf;
            r_hold.ref_cnt <= RES_CNT_W'(r_ref_cnt);
            r_hold.val_cnt <= RES_CNT_W'(r_val_cnt);
            r_pend         <= 1'b1;
          end
          // The closing rise has already been consumed, so ARM waits for the next one
          r_state <= (i_run && i_en) ? ST_ARM : ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pend = r_pend;
  assign o_res  = r_hold;
  assign o_lost = r_lost;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel reciprocal frequency / duty meter: N_CH channel instances,
// a round-robin arbiter over their pending results and one output register
// feeding a valid/ready stream.
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_CH-1:0]         sig_i,
  input  logic                    run_i,
  input  logic [N_CH-1:0]         ch_en_i,
  input  logic                    mode_i,
  input  logic [CNT_W-1:0]        gate_time_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [$clog2(N_CH)-1:0] res_ch_o,
  output logic [2*CNT_W-1:0]      res_data_o,
  output logic                    res_ovf_o,
  output logic [N_CH-1:0]         lost_o
);

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] w_pend;
  logic [N_CH-1:0] w_take;
  res_t            w_res [N_CH];
  res_t            w_sel;
  logic            w_grant_vld;
  logic [CH_W-1:0] w_grant_ch;
  logic            w_load;

  logic [CH_W-1:0]    r_ptr;
  logic               r_valid;
  logic [CH_W-1:0]    r_ch;
  logic [2*CNT_W-1:0] r_data;
  logic               r_ovf;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    freq_meter_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .i_sig       (sig_i[c]),
      .i_run       (run_i),
      .i_en        (ch_en_i[c]),
      .i_mode      (mode_i),
      .i_gate_time (gate_time_i),
      .i_take      (w_take[c]),
      .o_pend      (w_pend[c]),
      .o_res       (w_res[c]),
      .o_lost      (lost_o[c])
    );
  end

  // Round-robin pick: first pending channel at or after the pointer
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_pend[CH_W'((int'(r_ptr) + k) % N_CH)]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = CH_W'((int'(r_ptr) + k) % N_CH);
      end
    end
  end

  // Output register takes a new result when empty or being emptied this cycle
  assign w_load = w_grant_vld & (~r_valid | res_ready_i);
  assign w_sel  = w_res[w_grant_ch];

  // Tell the granted channel its holding register has been consumed
  always_comb begin
    w_take = '0;
    if (w_load) begin
      w_take[w_grant_ch] = 1'b1;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_ch    <= w_grant_ch;
        r_data  <= {w_sel.ref_cnt[CNT_W-1:0], w_sel.val_cnt[CNT_W-1:0]};
        r_ovf   <= w_sel.ovf;
        r_ptr   <= CH_W'((int'(w_grant_ch) + 1) % N_CH);
      end else if (res_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign res_valid_o = r_valid;
  assign res_ch_o    = r_ch;
  assign res_data_o  = r_data;
  assign res_ovf_o   = r_ovf;

endmodule
